// File: rtl/traffic_gen.sv
// traffic_gen: per-port pseudo-random packet descriptor generator for NoC interface testing.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   o_valid    [0:N-1]  packet present on port p this cycle
//   o_data     [0:N-1]  WIDTH-bit payload (header + XOR byte pattern)
//   o_dest     [0:N-1]  destination port index, never p itself
//   o_pktsize  [0:N-1]  packet length in bytes, 64..1518
module traffic_gen #(
    parameter int          WIDTH = 12144,
    parameter int          N     = 16,
    parameter logic [31:0] SEED  = 32'd1,
    parameter int          RATE  = 64
) (
    input  logic             clk,
    input  logic             reset,
    output logic             o_valid   [0:N-1],
    output logic [WIDTH-1:0] o_data    [0:N-1],
    output logic [7:0]       o_dest    [0:N-1],
    output logic [15:0]      o_pktsize [0:N-1]
);
    // The pattern is built at least 64 bits wide so the header always fits, then truncated to WIDTH.
    localparam int          NB   = ((WIDTH + 7) / 8 < 8) ? 8 : (WIDTH + 7) / 8;
    localparam int          PW   = NB * 8;
    localparam logic [31:0] POLY = 32'h80200003;
    for (genvar p = 0; p < N; p++) begin : g_port
        // A zero seed would lock the LFSR, so it is replaced by 1.
        localparam logic [31:0] SX = SEED ^ (32'(p) * 32'h9E3779B9);
        localparam logic [31:0] SP = (SX == 32'h0) ? 32'h1 : SX;
        logic [31:0]      r_lfsr;
        logic [31:0]      r_seq;
        logic             r_valid;
        logic [WIDTH-1:0] r_data;
        logic [7:0]       r_dest;
        logic [15:0]      r_size;
        logic [31:0]      w_r;
        logic             w_fire;
        logic [7:0]       w_d0;
        logic [7:0]       w_dest;
        logic [15:0]      w_size;
        logic [PW-1:0]    w_pat;
        assign w_r    = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? POLY : 32'h0);
        // 9-bit compare so RATE=256 fires every cycle.
        assign w_fire = {1'b0, w_r[7:0]} < 9'(RATE);
        assign w_d0   = 8'({1'b0, w_r[15:8]} % 9'(N));
        assign w_dest = (w_d0 == 8'(p)) ? 8'((9'(w_d0) + 9'd1) % 9'(N)) : w_d0;
        assign w_size = 16'd64 + (w_r[31:16] % 16'd1455);
        always_comb begin
            w_pat       = '0;
            w_pat[63:0] = {w_size, w_dest, 8'(p), r_seq};
            for (int k = 8; k < NB; k++)
                w_pat[8*k +: 8] = (k < int'(w_size)) ? (8'(k) ^ r_seq[7:0]) : 8'h0;
        end
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_lfsr  <= SP;
                r_seq   <= '0;
                r_valid <= 1'b0;
                r_data  <= '0;
                r_dest  <= '0;
                r_size  <= '0;
            end else begin
                r_lfsr  <= w_r;
                r_valid <= w_fire;
                r_data  <= w_fire ? w_pat[WIDTH-1:0] : '0;
                r_dest  <= w_fire ? w_dest : 8'h0;
                r_size  <= w_fire ? w_size : 16'h0;
                r_seq   <= r_seq + 32'(w_fire);
            end
        end
        assign o_valid[p]   = r_valid;
        assign o_data[p]    = r_data;
        assign o_dest[p]    = r_dest;
        assign o_pktsize[p] = r_size;
    end
endmodule

// File: tb/tb_traffic_gen.sv
// tb_traffic_gen: randomized-traffic bench comparing traffic_gen instances against a behavioural model.
module tb_traffic_gen;
    localparam int N  = 16;
    localparam int W  = 12144;
    localparam int NW = 64;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    logic          v0 [0:N-1];
    logic [W-1:0]  d0 [0:N-1];
    logic [7:0]    t0 [0:N-1];
    logic [15:0]   s0 [0:N-1];
    logic          vt [0:N-1];
    logic [W-1:0]  dt [0:N-1];
    logic [7:0]    tt [0:N-1];
    logic [15:0]   st [0:N-1];
    logic          v1 [0:N-1], v2 [0:N-1], v3 [0:N-1], v4 [0:N-1];
    logic [NW-1:0] d1 [0:N-1], d2 [0:N-1], d3 [0:N-1], d4 [0:N-1];
    logic [7:0]    t1 [0:N-1], t2 [0:N-1], t3 [0:N-1], t4 [0:N-1];
    logic [15:0]   s1 [0:N-1], s2 [0:N-1], s3 [0:N-1], s4 [0:N-1];

    traffic_gen #(.WIDTH(W), .N(N), .SEED(32'd1), .RATE(64)) u_main
        (.clk(clk), .reset(rst_a), .o_valid(v0), .o_data(d0), .o_dest(t0), .o_pktsize(s0));
    traffic_gen #(.WIDTH(W), .N(N), .SEED(32'd1), .RATE(64)) u_twin
        (.clk(clk), .reset(rst_b), .o_valid(vt), .o_data(dt), .o_dest(tt), .o_pktsize(st));
    traffic_gen #(.WIDTH(NW), .N(N), .SEED(32'd2), .RATE(64)) u_seed2
        (.clk(clk), .reset(rst_b), .o_valid(v1), .o_data(d1), .o_dest(t1), .o_pktsize(s1));
    traffic_gen #(.WIDTH(NW), .N(N), .SEED(32'h9E3779B9), .RATE(64)) u_gold
        (.clk(clk), .reset(rst_b), .o_valid(v2), .o_data(d2), .o_dest(t2), .o_pktsize(s2));
    traffic_gen #(.WIDTH(NW), .N(N), .SEED(32'd1), .RATE(0)) u_r0
        (.clk(clk), .reset(rst_b), .o_valid(v3), .o_data(d3), .o_dest(t3), .o_pktsize(s3));
    traffic_gen #(.WIDTH(NW), .N(N), .SEED(32'd1), .RATE(256)) u_r256
        (.clk(clk), .reset(rst_b), .o_valid(v4), .o_data(d4), .o_dest(t4), .o_pktsize(s4));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int u, input int p, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s unit %0d port %0d got %0h expected %0h", nm, u, p, a, e);
        end
    endtask

    task automatic rng(input string nm, input longint a, input longint lo, input longint hi);
        checks++;
        if (a < lo || a > hi) begin
            errors++;
            $display("FAIL %s got %0d expected %0d..%0d", nm, a, lo, hi);
        end
    endtask

    function automatic logic [31:0] nx(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
    endfunction

    function automatic logic [31:0] sd(input logic [31:0] b, input int p);
        logic [31:0] x;
        x = b ^ (32'(p) * 32'h9E3779B9);
        return (x == 32'h0) ? 32'h1 : x;
    endfunction

    // Model units: 0 main/twin, 1 seed 2, 2 seed 0x9E3779B9, 3 rate 0, 4 rate 256.
    int          rate_of [0:4] = '{64, 64, 64, 0, 256};
    logic [31:0] seed_of [0:4] = '{32'd1, 32'd2, 32'h9E3779B9, 32'd1, 32'd1};
    logic [31:0] m_lfsr [0:4][0:N-1];
    logic [31:0] m_seq  [0:4][0:N-1];
    logic        ev     [0:4][0:N-1];
    logic [7:0]  edst   [0:4][0:N-1];
    logic [15:0] esz    [0:4][0:N-1];
    logic [31:0] eseq   [0:4][0:N-1];

    int          mode = 0;
    int          idx = 0, idx_b = 0;
    longint      fires = 0, tot = 0;
    int          seen64 = 0, seen1518 = 0, diff2 = 0, gold1 = 0;
    int          cnt_pk [0:N-1];
    int          cnt256 [0:N-1];
    logic [31:0] last256 [0:N-1];
    logic [24:0] sig [1:100][0:N-1];

    logic [31:0] r;
    logic [7:0]  dd, eb, at;
    logic        rs, av;
    logic [63:0] ad;
    logic [15:0] asz;
    int          bad;

    always @(posedge clk) begin
        #1;
        idx   = rst_a ? idx + 1 : 0;
        idx_b = rst_b ? idx_b + 1 : 0;
        for (int i = 0; i < 5; i++) begin
            for (int p = 0; p < N; p++) begin
                rs = (i == 0) ? rst_a : rst_b;
                if (!rs) begin
                    m_lfsr[i][p] = sd(seed_of[i], p);
                    m_seq[i][p]  = 0;
                    ev[i][p]     = 1'b0;
                    edst[i][p]   = 8'h0;
                    esz[i][p]    = 16'h0;
                    eseq[i][p]   = 0;
                end else begin
                    r            = nx(m_lfsr[i][p]);
                    m_lfsr[i][p] = r;
                    ev[i][p]     = int'(r[7:0]) < rate_of[i];
                    dd           = 8'(int'(r[15:8]) % N);
                    if (int'(dd) == p) dd = 8'((int'(dd) + 1) % N);
                    edst[i][p]   = ev[i][p] ? dd : 8'h0;
                    esz[i][p]    = ev[i][p] ? 16'(64 + int'(r[31:16]) % 1455) : 16'h0;
                    eseq[i][p]   = m_seq[i][p];
                    if (ev[i][p]) m_seq[i][p] = m_seq[i][p] + 1;
                end
            end
        end
        for (int p = 0; p < N; p++) begin
            if (!rst_a) cnt_pk[p] = 0;
            if (!rst_b) cnt256[p] = 0;
            chk("valid", 0, p, 64'(v0[p]), 64'(ev[0][p]));
            chk("dest", 0, p, 64'(t0[p]), 64'(edst[0][p]));
            chk("size", 0, p, 64'(s0[p]), 64'(esz[0][p]));
            if (ev[0][p]) begin
                chk("header", 0, p, d0[p][63:0], {esz[0][p], edst[0][p], 8'(p), eseq[0][p]});
                bad = 0;
                for (int k = 8; k < W / 8; k++) begin
                    eb = (k < int'(esz[0][p])) ? (8'(k) ^ eseq[0][p][7:0]) : 8'h0;
                    if (d0[p][8*k +: 8] !== eb) bad++;
                end
                chk("payload_bad_bytes", 0, p, 64'(bad), 64'd0);
                chk("dest_is_self", 0, p, 64'(t0[p] == 8'(p)), 64'd0);
                chk("dest_in_range", 0, p, 64'(t0[p] < 8'd16), 64'd1);
                chk("size_in_range", 0, p, 64'(s0[p] >= 16'd64 && s0[p] <= 16'd1518), 64'd1);
                chk("seq_step", 0, p, 64'(d0[p][31:0]), 64'(cnt_pk[p]));
                cnt_pk[p]++;
                if (esz[0][p] == 16'd64) begin
                    seen64++;
                    chk("sz64_last_byte", 0, p, 64'(d0[p][511:504]), 64'(8'h3F ^ eseq[0][p][7:0]));
                    chk("sz64_first_pad", 0, p, 64'(d0[p][519:512]), 64'd0);
                end
                if (esz[0][p] == 16'd1518) begin
                    seen1518++;
                    chk("sz1518_last_byte", 0, p, 64'(d0[p][12143:12136]), 64'(8'hED ^ eseq[0][p][7:0]));
                end
            end else begin
                chk("data_zero", 0, p, 64'(d0[p] != '0), 64'd0);
            end
            if (rst_a) begin
                tot++;
                fires += longint'(v0[p]);
            end
            if (rst_a && mode < 2) begin
                chk("twin_valid", 0, p, 64'(vt[p]), 64'(v0[p]));
                chk("twin_dest", 0, p, 64'(tt[p]), 64'(t0[p]));
                chk("twin_size", 0, p, 64'(st[p]), 64'(s0[p]));
                chk("twin_data_differs", 0, p, 64'(dt[p] !== d0[p]), 64'd0);
                if (v1[p] !== v0[p] || t1[p] !== t0[p]) diff2++;
            end
            if (rst_a && idx >= 1 && idx <= 100) begin
                if (mode == 1) sig[idx][p] = {v0[p], t0[p], s0[p]};
                else if (mode == 2) chk("replay", 0, p, 64'({v0[p], t0[p], s0[p]}), 64'(sig[idx][p]));
            end
            for (int i = 1; i < 5; i++) begin
                av  = (i == 1) ? v1[p] : (i == 2) ? v2[p] : (i == 3) ? v3[p] : v4[p];
                ad  = (i == 1) ? d1[p] : (i == 2) ? d2[p] : (i == 3) ? d3[p] : d4[p];
                at  = (i == 1) ? t1[p] : (i == 2) ? t2[p] : (i == 3) ? t3[p] : t4[p];
                asz = (i == 1) ? s1[p] : (i == 2) ? s2[p] : (i == 3) ? s3[p] : s4[p];
                chk("n_valid", i, p, 64'(av), 64'(ev[i][p]));
                chk("n_dest", i, p, 64'(at), 64'(edst[i][p]));
                chk("n_size", i, p, 64'(asz), 64'(esz[i][p]));
                chk("n_data", i, p, ad, ev[i][p] ? {esz[i][p], edst[i][p], 8'(p), eseq[i][p]} : 64'd0);
            end
            if (v2[p] && p == 1) gold1++;
            if (v4[p]) begin
                cnt256[p]++;
                last256[p] = d4[p][31:0];
            end
        end
        if (idx == 1) begin
            chk("lit_c1_valid", 0, 0, 64'(v0[0]), 64'd1);
            chk("lit_c1_dest", 0, 0, 64'(t0[0]), 64'd1);
            chk("lit_c1_size", 0, 0, 64'(s0[0]), 64'd854);
            chk("lit_c1_header", 0, 0, d0[0][63:0], {16'd854, 8'd1, 8'd0, 32'd0});
        end
        if (idx == 2) begin
            chk("lit_c2_size", 0, 0, 64'(s0[0]), 64'd1249);
            chk("lit_c2_dest", 0, 0, 64'(t0[0]), 64'd1);
            chk("lit_c2_seq", 0, 0, 64'(d0[0][31:0]), 64'd1);
        end
        if (idx_b == 1) begin
            chk("lit_zero_seed_valid", 2, 1, 64'(v2[1]), 64'd1);
            chk("lit_zero_seed_dest", 2, 1, 64'(t2[1]), 64'd0);
            chk("lit_zero_seed_size", 2, 1, 64'(s2[1]), 64'd854);
        end
    end

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (3) @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (20) @(negedge clk);
        @(posedge clk);
        #3;
        rst_a = 1'b0;
        rst_b = 1'b0;
        #1;
        for (int p = 0; p < N; p++) begin
            chk("async_valid", 0, p, 64'(v0[p]), 64'd0);
            chk("async_data", 0, p, 64'(d0[p] != '0), 64'd0);
            chk("async_dest", 0, p, 64'(t0[p]), 64'd0);
            chk("async_size", 0, p, 64'(s0[p]), 64'd0);
            chk("async_r256_valid", 4, p, 64'(v4[p]), 64'd0);
        end
        repeat (5) @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b1;
        mode  = 1;
        repeat (5000) @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        mode  = 2;
        repeat (4999) @(negedge clk);
        rng("fire_rate_permille", (fires * 1000) / tot, 230, 270);
        rng("seen_size64", seen64, 1, 1000000);
        rng("seen_size1518", seen1518, 1, 1000000);
        rng("seed2_differs", diff2, 1, 1000000);
        rng("zero_seed_port_fires", gold1, 1, 1000000);
        chk("run_length", 4, 0, 64'(idx_b), 64'd10000);
        for (int p = 0; p < N; p++) begin
            chk("r256_count", 4, p, 64'(cnt256[p]), 64'd10000);
            chk("r256_last_seq", 4, p, 64'(last256[p]), 64'd9999);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
